seg_value_encoder: RTL and testbench



---
 rtl/seg_value_encoder.sv | 152 +++++++++++++++
 tb/tb_seg_value_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_value_encoder.sv
// rtl/seg_value_encoder.sv - iterative double-dabble binary to 4-digit active-low 7-segment encoder
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits in dig1..dig3.
module seg_value_encoder #(
    parameter int WIDTH   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       dp_in,
    output logic [7:0]       dig1,
    output logic [7:0]       dig2,
    output logic [7:0]       dig3,
    output logic [7:0]       dig4,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    localparam logic [7:0] PAT_DASH  = 8'hBF;
    localparam logic [7:0] PAT_BLANK = 8'hFF;

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [15:0]      bcd;
    logic [3:0]       dp_q;
    logic             ovf_q;
    logic [4:0]       iter;

    logic [15:0]       bcd_adj;
    logic [WIDTH+15:0] shifted;
    logic [31:0]       value_ext;
    logic              value_ovf;
    logic [7:0]        pat [4];
    logic [3:0]        nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic              lead;
`endif

    assign in_ready = (state == IDLE);

    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        logic [7:0] p;
        case (n)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = PAT_BLANK;
        endcase
        return p;
    endfunction

    // One double-dabble iteration: correct every nibble, then shift the whole {bcd, bin} pair.
    always_comb begin
        bcd_adj = {dabble(bcd[15:12]), dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
        shifted = {bcd_adj, bin} << 1;
    end

    assign value_ext = {{(32-WIDTH){1'b0}}, value};
    assign value_ovf = (value_ext > $unsigned(MAX_VAL));

    // pat[0] is dig1 (thousands), pat[3] is dig4 (units).
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
`endif
        nib = 4'd0;
        for (int i = 0; i < 4; i++) begin
            nib = bcd[15-4*i -: 4];
            if (ovf_q)
                pat[i] = PAT_DASH;
            else
                pat[i] = seg_code(nib);
`ifdef LEADING_ZERO_BLANK_EN
            if (!ovf_q && i < 3) begin
                if (lead && nib == 4'd0)
                    pat[i] = PAT_BLANK;
                else
                    lead = 1'b0;
            end
`endif
            if (dp_q[3-i])
                pat[i][7] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            dp_q  <= '0;
            ovf_q <= 1'b0;
            iter  <= '0;
            dig1  <= PAT_BLANK;
            dig2  <= PAT_BLANK;
            dig3  <= PAT_BLANK;
            dig4  <= PAT_BLANK;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin   <= value;
                        dp_q  <= dp_in;
                        ovf_q <= value_ovf;
                        bcd   <= '0;
                        iter  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= shifted;
                    iter       <= iter + 5'd1;
                    if (iter == 5'(WIDTH-1))
                        state <= ENCODE;
                end
                ENCODE: begin
                    dig1  <= pat[0];
                    dig2  <= pat[1];
                    dig3  <= pat[2];
                    dig4  <= pat[3];
                    ovf   <= ovf_q;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_value_encoder.sv
// tb/tb_seg_value_encoder.sv - table-driven and scoreboard bench for seg_value_encoder
module tb_seg_value_encoder;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] value = '0;
    logic [3:0]   dp_in = 4'd0;
    logic [7:0]   dig1, dig2, dig3, dig4;
    logic         done, ovf;

    seg_value_encoder #(.WIDTH(W), .MAX_VAL(9999)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .value    (value),
        .dp_in    (dp_in),
        .dig1     (dig1),
        .dig2     (dig2),
        .dig3     (dig3),
        .dig4     (dig4),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] d1, d2, d3, d4;
        logic       ovf;
        int         acc;
    } exp_t;

    typedef struct {
        int         v;
        logic [3:0] dp;
        logic [7:0] e1, e2, e3, e4;
        logic       eo;
    } vec_t;

    exp_t sb[$];
    int   acc_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input int v, input logic [3:0] dp);
        exp_t       e;
        logic [7:0] codes [10];
        logic [7:0] p [4];
        int         d [4];
        bit         lead;
        codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        d[0] = (v / 1000) % 10;
        d[1] = (v / 100) % 10;
        d[2] = (v / 10) % 10;
        d[3] = v % 10;
        lead = 1'b1;
        for (int i = 0; i < 4; i++)
            p[i] = (v > 9999) ? 8'hBF : codes[d[i]];
`ifdef LEADING_ZERO_BLANK_EN
        if (v <= 9999) begin
            for (int i = 0; i < 3; i++) begin
                if (lead && d[i] == 0) p[i] = 8'hFF;
                else lead = 1'b0;
            end
        end
`endif
        for (int i = 0; i < 4; i++)
            if (dp[3-i]) p[i][7] = 1'b0;
        e.d1 = p[0]; e.d2 = p[1]; e.d3 = p[2]; e.d4 = p[3];
        e.ovf = (v > 9999);
        e.acc = 0;
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            mon_e = model(int'(value), dp_in);
            mon_e.acc = cyc + 1;
            sb.push_back(mon_e);
            acc_cnt++;
        end
        if (rst_n && done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            chk("sb_nonempty_at_done", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("sb_dig1", dig1, mon_e.d1);
                chk("sb_dig2", dig2, mon_e.d2);
                chk("sb_dig3", dig3, mon_e.d3);
                chk("sb_dig4", dig4, mon_e.d4);
                chk("sb_ovf", ovf, mon_e.ovf);
                chk("sb_latency", cyc - mon_e.acc, W + 1);
            end
        end
    end

    task automatic request(input int v, input logic [3:0] dp);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_req", in_ready, 1);
        value = W'(v);
        dp_in = dp;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        chk({name, "_done_seen"}, ok, 1);
    endtask

    vec_t tbl [8];
    bit   ok;
    logic [7:0] saved;
    int   d0, a0, n, ds;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1234,  4'b0000, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0};
        tbl[1] = '{10000, 4'b0010, 8'hBF, 8'hBF, 8'h3F, 8'hBF, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[2] = '{7,     4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 1'b0};
        tbl[3] = '{0,     4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 1'b0};
        tbl[4] = '{5,     4'b1000, 8'h7F, 8'hFF, 8'hFF, 8'h92, 1'b0};
`else
        tbl[2] = '{7,     4'b0000, 8'hC0, 8'hC0, 8'hC0, 8'hF8, 1'b0};
        tbl[3] = '{0,     4'b0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1'b0};
        tbl[4] = '{5,     4'b1000, 8'h40, 8'hC0, 8'hC0, 8'h92, 1'b0};
`endif
        tbl[5] = '{9999,  4'b1111, 8'h10, 8'h10, 8'h10, 8'h10, 1'b0};
        tbl[6] = '{16383, 4'b0000, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 1'b1};
        tbl[7] = '{2468,  4'b0000, 8'hA4, 8'h99, 8'h82, 8'h80, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dig1", dig1, 8'hFF);
        chk("rst_dig4", dig4, 8'hFF);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (tbl[i]) begin
            request(tbl[i].v, tbl[i].dp);
            wait_done("tbl", ok);
            if (ok) begin
                chk("tbl_dig1", dig1, tbl[i].e1);
                chk("tbl_dig2", dig2, tbl[i].e2);
                chk("tbl_dig3", dig3, tbl[i].e3);
                chk("tbl_dig4", dig4, tbl[i].e4);
                chk("tbl_ovf", ovf, tbl[i].eo);
            end
        end

        // Request while busy is ignored and outputs hold until done
        saved = dig1;
        request(9999, 4'b0000);
        value = W'(1);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("busy_ready_low", in_ready, 0);
            chk("busy_dig_hold", dig1, saved);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done("busy", ok);
        if (ok) begin
            chk("busy_dig1", dig1, 8'h90);
            chk("busy_dig4", dig4, 8'h90);
        end
        repeat (3) @(negedge clk);
        chk("busy_sb_empty", sb.size(), 0);

        // Reset mid-conversion aborts without a done pulse
        request(4321, 4'b0000);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_dig1", dig1, 8'hFF);
        chk("abort_dig3", dig3, 8'hFF);
        chk("abort_ovf", ovf, 0);
        chk("abort_done", done, 0);
        chk("abort_ready", in_ready, 1);
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_ready_after", in_ready, 1);
        chk("abort_dig_after", dig2, 8'hFF);

        // Back-to-back with in_valid held high
        ds = done_cyc.size();
        @(posedge clk); #1;
        value = W'(0);
        dp_in = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a0 = acc_cnt;
            n = 0;
            while (acc_cnt == a0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_accept", acc_cnt, a0 + 1);
            @(posedge clk); #1;
            if (i == 0) value = W'(5);
            else if (i == 1) value = W'(9999);
            else in_valid = 1'b0;
        end
        n = 0;
        while (done_cyc.size() < ds + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_three_done", done_cyc.size(), ds + 3);
        if (done_cyc.size() >= ds + 3) begin
            chk("b2b_spacing1", done_cyc[ds+1] - done_cyc[ds], W + 2);
            chk("b2b_spacing2", done_cyc[ds+2] - done_cyc[ds+1], W + 2);
        end
        chk("b2b_last_dig4", dig4, 8'h90);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
